// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, ALU/load write ports, load-issue scoreboard and status.
// master drives addresses, write data and load issue; slave is the register file itself.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) ();
  localparam int NREGS = 1 << ADDR_W;

  logic [ADDR_W-1:0] A1, A2, A3;
  logic              RV1, RV2, RV3;
  logic [DATA_W-1:0] RD1, RD2, RD3;
  logic [DATA_W-1:0] R15;
  logic              WE3;
  logic [DATA_W-1:0] WD3;
  logic              WE4;
  logic [ADDR_W-1:0] A4;
  logic [DATA_W-1:0] WD4;
  logic              LD_ISSUE;
  logic [ADDR_W-1:0] LD_ADDR;
  logic              STALL;
  logic [NREGS-1:0]  BUSY;
  logic              ERR;

  modport master (
    output A1, A2, A3, RV1, RV2, RV3, R15,
    output WE3, WD3, WE4, A4, WD4, LD_ISSUE, LD_ADDR,
    input  RD1, RD2, RD3, STALL, BUSY, ERR
  );

  modport slave (
    input  A1, A2, A3, RV1, RV2, RV3, R15,
    input  WE3, WD3, WE4, A4, WD4, LD_ISSUE, LD_ADDR,
    output RD1, RD2, RD3, STALL, BUSY, ERR
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with three combinational read ports, ALU + load writeback ports and a pending-load scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding and writeback stall release.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  regfile_sb_if.slave   bus
);
  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_IDX = {ADDR_W{1'b1}};

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              err_q, err_d;

  logic              wr3, wr4, ld_ok;
  logic [NREGS-1:0]  iss_oh, wb_oh, stall_mask;

  logic [ADDR_W-1:0] rd_addr [3];
  logic              rd_vld  [3];
  logic [DATA_W-1:0] rd_data [3];
  logic [2:0]        port_stall;

  // The PC slot is never stored, so any write or issue aimed at it is discarded here.
  assign wr3   = bus.WE3 && (bus.A3 != PC_IDX);
  assign wr4   = bus.WE4 && (bus.A4 != PC_IDX);
  assign ld_ok = bus.LD_ISSUE && (bus.LD_ADDR != PC_IDX);

  assign rd_addr[0] = bus.A1;
  assign rd_addr[1] = bus.A2;
  assign rd_addr[2] = bus.A3;
  assign rd_vld[0]  = bus.RV1;
  assign rd_vld[1]  = bus.RV2;
  assign rd_vld[2]  = bus.RV3;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // ALU result is the younger instruction and wins a same-register collision.
      if (wr4 && !(wr3 && (bus.A3 == bus.A4))) begin
        regs_q[bus.A4] <= bus.WD4;
      end
      if (wr3) begin
        regs_q[bus.A3] <= bus.WD3;
      end
    end
  end

  always_comb begin
    iss_oh = '0;
    wb_oh  = '0;
    if (ld_ok) begin
      iss_oh[bus.LD_ADDR] = 1'b1;
    end
    if (wr4) begin
      wb_oh[bus.A4] = 1'b1;
    end
  end

  // Issue overrides a same-cycle writeback: the new load is still in flight.
  assign busy_d = (busy_q & ~wb_oh) | iss_oh;
  assign err_d  = err_q | (|(iss_oh & busy_q));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign stall_mask = busy_q & ~(wb_oh & ~iss_oh);
`else
  assign stall_mask = busy_q;
`endif

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr4 && (bus.A4 == rd_addr[p])) begin
        rd_data[p] = bus.WD4;
      end
      if (wr3 && (bus.A3 == rd_addr[p])) begin
        rd_data[p] = bus.WD3;
      end
`endif
      if (rd_addr[p] == PC_IDX) begin
        rd_data[p] = bus.R15;
      end
    end
  end

  always_comb begin
    port_stall = '0;
    for (int p = 0; p < 3; p++) begin
      port_stall[p] = rd_vld[p] && (rd_addr[p] != PC_IDX) && stall_mask[rd_addr[p]];
    end
  end

  assign bus.RD1   = rd_data[0];
  assign bus.RD2   = rd_data[1];
  assign bus.RD3   = rd_data[2];
  assign bus.STALL = |port_stall;
  assign bus.BUSY  = busy_q;
  assign bus.ERR   = err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: 32x16 and 16x8 instances against an array-based reference model.
module tb_regfile_sb;
  logic CLK = 1'b0;
  logic RST_N;

  always #5 CLK = ~CLK;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) bus_a ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) bus_b ();

  regfile_sb #(.DATA_W(32), .ADDR_W(4)) dut_a (.CLK(CLK), .RST_N(RST_N), .bus(bus_a));
  regfile_sb #(.DATA_W(16), .ADDR_W(3)) dut_b (.CLK(CLK), .RST_N(RST_N), .bus(bus_b));

  typedef struct {
    logic [3:0]  a1, a2, a3, a4, ld_addr;
    logic        rv1, rv2, rv3, we3, we4, ld;
    logic [31:0] r15, wd3, wd4;
  } stim_t;

  typedef struct {
    int          inst;
    logic [31:0] rd1, rd2, rd3;
    logic        stall;
    logic [15:0] busy;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  logic [31:0] m_reg  [2][16];
  logic [15:0] m_busy [2];
  logic        m_err  [2];

  function automatic int pc_of(int inst);
    return (inst == 0) ? 15 : 7;
  endfunction

  function automatic logic [31:0] mask_of(int inst);
    return (inst == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{a1: 4'd0, a2: 4'd0, a3: 4'd0, a4: 4'd0, ld_addr: 4'd0,
          rv1: 1'b0, rv2: 1'b0, rv3: 1'b0, we3: 1'b0, we4: 1'b0, ld: 1'b0,
          r15: 32'h0000_1000, wd3: 32'h0, wd4: 32'h0};
    return s;
  endfunction

  function automatic stim_t rand_stim(int inst);
    stim_t s;
    int    pc = pc_of(inst);
    s.a1 = 4'($urandom_range(pc, 0));
    s.a2 = 4'($urandom_range(pc, 0));
    s.a3 = 4'($urandom_range(pc, 0));
    s.a4 = 4'($urandom_range(pc, 0));
    s.ld_addr = 4'($urandom_range(pc, 0));
    s.rv1 = 1'($urandom_range(1, 0));
    s.rv2 = 1'($urandom_range(1, 0));
    s.rv3 = 1'($urandom_range(1, 0));
    s.we3 = ($urandom_range(99, 0) < 50);
    s.we4 = ($urandom_range(99, 0) < 35);
    s.ld  = ($urandom_range(99, 0) < 20);
    s.r15 = $urandom();
    s.wd3 = $urandom();
    s.wd4 = $urandom();
    return s;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 16; r++) m_reg[i][r] = 32'h0;
      m_busy[i] = 16'h0;
      m_err[i]  = 1'b0;
    end
  endfunction

  function automatic logic [31:0] exp_read(int inst, logic [3:0] a, stim_t s);
    logic [31:0] mk = mask_of(inst);
    if (int'(a) == pc_of(inst)) return s.r15 & mk;
`ifdef REGFILE_BYPASS_EN
    if (s.we3 && s.a3 == a) return s.wd3 & mk;
    if (s.we4 && s.a4 == a) return s.wd4 & mk;
`endif
    return m_reg[inst][a];
  endfunction

  function automatic logic exp_pending(int inst, logic [3:0] a, stim_t s);
    logic p;
    if (int'(a) == pc_of(inst)) return 1'b0;
    p = m_busy[inst][a];
`ifdef REGFILE_BYPASS_EN
    if (s.we4 && s.a4 == a && !(s.ld && s.ld_addr == a)) p = 1'b0;
`endif
    return p;
  endfunction

  function automatic void model_step(int inst, stim_t s);
    int          pc = pc_of(inst);
    logic [31:0] mk = mask_of(inst);
    if (s.ld && int'(s.ld_addr) != pc && m_busy[inst][s.ld_addr]) m_err[inst] = 1'b1;
    if (s.we4 && int'(s.a4) != pc) m_reg[inst][s.a4] = s.wd4 & mk;
    if (s.we3 && int'(s.a3) != pc) m_reg[inst][s.a3] = s.wd3 & mk;
    if (s.we4) m_busy[inst][s.a4] = 1'b0;
    if (s.ld && int'(s.ld_addr) != pc) m_busy[inst][s.ld_addr] = 1'b1;
  endfunction

  function automatic void push_exp(int inst, stim_t s);
    exp_t e;
    e.inst  = inst;
    e.rd1   = exp_read(inst, s.a1, s);
    e.rd2   = exp_read(inst, s.a2, s);
    e.rd3   = exp_read(inst, s.a3, s);
    e.stall = (s.rv1 && exp_pending(inst, s.a1, s)) ||
              (s.rv2 && exp_pending(inst, s.a2, s)) ||
              (s.rv3 && exp_pending(inst, s.a3, s));
    e.busy  = m_busy[inst];
    e.err   = m_err[inst];
    q.push_back(e);
  endfunction

  task automatic drive(int inst, stim_t s);
    if (inst == 0) begin
      bus_a.A1 = s.a1; bus_a.A2 = s.a2; bus_a.A3 = s.a3; bus_a.A4 = s.a4;
      bus_a.RV1 = s.rv1; bus_a.RV2 = s.rv2; bus_a.RV3 = s.rv3;
      bus_a.R15 = s.r15; bus_a.WE3 = s.we3; bus_a.WD3 = s.wd3;
      bus_a.WE4 = s.we4; bus_a.WD4 = s.wd4;
      bus_a.LD_ISSUE = s.ld; bus_a.LD_ADDR = s.ld_addr;
    end else begin
      bus_b.A1 = s.a1[2:0]; bus_b.A2 = s.a2[2:0]; bus_b.A3 = s.a3[2:0]; bus_b.A4 = s.a4[2:0];
      bus_b.RV1 = s.rv1; bus_b.RV2 = s.rv2; bus_b.RV3 = s.rv3;
      bus_b.R15 = s.r15[15:0]; bus_b.WE3 = s.we3; bus_b.WD3 = s.wd3[15:0];
      bus_b.WE4 = s.we4; bus_b.WD4 = s.wd4[15:0];
      bus_b.LD_ISSUE = s.ld; bus_b.LD_ADDR = s.ld_addr[2:0];
    end
  endtask

  // One clock of stimulus on one instance; the other instance sits idle.
  task automatic cyc(int inst, stim_t s);
    drive(inst, s);
    drive(1 - inst, idle());
    #1;
    push_exp(inst, s);
    @(negedge CLK);
    @(posedge CLK);
    model_step(inst, s);
    #1;
  endtask

  // Asynchronous reset pulse, checked on both instances while RST_N is still low.
  task automatic reset_pulse(stim_t s0);
    drive(0, s0);
    drive(1, idle());
    RST_N = 1'b0;
    model_clear();
    #1;
    push_exp(0, s0);
    push_exp(1, idle());
    @(negedge CLK);
    RST_N = 1'b1;
    drive(0, idle());
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(string nm, int inst, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL inst%0d %s: got 0x%08h expected 0x%08h at %0t", inst, nm, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.inst == 0) begin
          chk("rd1", 0, bus_a.RD1, e.rd1);
          chk("rd2", 0, bus_a.RD2, e.rd2);
          chk("rd3", 0, bus_a.RD3, e.rd3);
          chk("stall", 0, {31'b0, bus_a.STALL}, {31'b0, e.stall});
          chk("busy", 0, {16'b0, bus_a.BUSY}, {16'b0, e.busy});
          chk("err", 0, {31'b0, bus_a.ERR}, {31'b0, e.err});
        end else begin
          chk("rd1", 1, {16'b0, bus_b.RD1}, e.rd1);
          chk("rd2", 1, {16'b0, bus_b.RD2}, e.rd2);
          chk("rd3", 1, {16'b0, bus_b.RD3}, e.rd3);
          chk("stall", 1, {31'b0, bus_b.STALL}, {31'b0, e.stall});
          chk("busy", 1, {24'b0, bus_b.BUSY}, {16'b0, e.busy});
          chk("err", 1, {31'b0, bus_b.ERR}, {31'b0, e.err});
        end
      end
    end
  end

  initial begin
    stim_t s;
    RST_N = 1'b0;
    model_clear();
    drive(0, idle());
    drive(1, idle());
    reset_pulse(idle());

    for (int a = 0; a < 16; a++) begin
      s = idle();
      s.a1 = 4'(a); s.a2 = 4'(a); s.a3 = 4'(a);
      cyc(0, s);
    end

    s = idle(); s.we3 = 1; s.a3 = 2; s.wd3 = 32'hDEAD_BEEF;
    s.we4 = 1; s.a4 = 2; s.wd4 = 32'h1234_5678; s.a1 = 2;
    cyc(0, s);
    s = idle(); s.a1 = 2; s.a2 = 2;
    cyc(0, s);
    s = idle(); s.we3 = 1; s.a3 = 15; s.wd3 = 32'hCAFE_F00D; s.a1 = 15; s.r15 = 32'h0000_2000;
    cyc(0, s);
    s = idle(); s.a1 = 15; s.a2 = 2; s.r15 = 32'h0000_2004;
    cyc(0, s);

    s = idle(); s.ld = 1; s.ld_addr = 5;
    cyc(0, s);
    s = idle(); s.a1 = 5; s.rv1 = 1;
    cyc(0, s);
    s = idle(); s.a1 = 5; s.rv1 = 1; s.we4 = 1; s.a4 = 5; s.wd4 = 32'h55;
    cyc(0, s);
    s = idle(); s.a1 = 5; s.rv1 = 1;
    cyc(0, s);

    s = idle(); s.ld = 1; s.ld_addr = 7;
    cyc(0, s);
    cyc(0, s);
    s = idle(); s.ld = 1; s.ld_addr = 7; s.we4 = 1; s.a4 = 7; s.wd4 = 32'h77;
    s.a1 = 7; s.rv1 = 1;
    cyc(0, s);
    s = idle(); s.a1 = 7; s.rv2 = 1; s.a2 = 7;
    cyc(0, s);
    reset_pulse(idle());

    s = idle(); s.ld = 1; s.ld_addr = 3;
    cyc(0, s);
    s = idle(); s.a1 = 3; s.rv1 = 0;
    cyc(0, s);
    s = idle(); s.ld = 1; s.ld_addr = 3;
    cyc(0, s);
    s = idle(); s.a1 = 3; s.rv1 = 1;
    reset_pulse(s);
    s = idle(); s.we4 = 1; s.a4 = 3; s.wd4 = 32'h33; s.a1 = 3; s.rv1 = 1;
    cyc(0, s);
    s = idle(); s.a1 = 3; s.rv1 = 1;
    cyc(0, s);

    for (int i = 0; i < 400; i++) cyc(0, rand_stim(0));

    for (int r = 0; r < 8; r++) begin
      s = idle(); s.we3 = 1; s.a3 = 4'(r); s.wd3 = (r == 6) ? 32'h0000_FFFF : 32'hABCD_0000 + 32'(r);
      s.a1 = 4'(r);
      cyc(1, s);
    end
    for (int r = 0; r < 8; r++) begin
      s = idle(); s.a1 = 4'(r); s.a2 = 4'((r + 1) % 8); s.a3 = 4'(7);
      s.r15 = 32'h0001_FFFE;
      cyc(1, s);
    end
    for (int i = 0; i < 200; i++) cyc(1, rand_stim(1));

    @(negedge CLK);
    #1;
    chk("queue_drained", 0, 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor of the single-cycle register file: DATA_W-bit × 2^ADDR_W register array, three combinational read ports, two synchronous write ports (ALU result and load writeback), asynchronous active-low reset, and a per-register pending-load scoreboard that raises a stall request. Sits in the decode/writeback stage of the multicycle and pipelined cores. The top index is the architectural PC, is not stored, and is sourced from fetch on every read port.

## Interface
- DATA_W, 32, register and data width
- ADDR_W, 4, register address width; NREGS = 2^ADDR_W, index NREGS-1 is the PC
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous active-low reset
- A1, A2, A3  in  ADDR_W each  read addresses (A3 is also the ALU write address)
- RV1, RV2, RV3  in  1 each  read-valid qualifiers for hazard checking
- RD1, RD2, RD3  out  DATA_W each  read data
- R15  in  DATA_W  current PC value
- WE3  in  1  ALU write enable; WD3 in DATA_W ALU write data
- WE4  in  1  load writeback enable; A4 in ADDR_W; WD4 in DATA_W
- LD_ISSUE  in  1  load issued; LD_ADDR in ADDR_W destination register
- STALL  out  1  a valid read hits a pending register
- BUSY  out  NREGS  pending bit per register (bit NREGS-1 always 0)
- ERR  out  1  sticky scoreboard error

## Operation
- Reset (RST_N low, asynchronous): all stored registers, pending bits, ERR cleared to 0. While in reset RDn = 0, except RDn = R15 when An = NREGS-1.
- Read: RDn = R15 if An = NREGS-1, else stored value of register An. Combinational; applies to all three ports.
- Write: at rising edge, WE3 writes WD3 to A3, WE4 writes WD4 to A4. Writes addressed to NREGS-1 are dropped; no state change.
- Same-address WE3 and WE4 in one cycle: WE3 data wins (younger instruction); pending bit still cleared by WE4.
- Scoreboard, per register r at rising edge:
  - set if LD_ISSUE and LD_ADDR = r;
  - else cleared if WE4 and A4 = r;
  - LD_ISSUE to NREGS-1 ignored.
- Issue wins over simultaneous writeback to the same register (new load in flight, bit stays 1).
- LD_ISSUE to a register already pending: bit stays 1, ERR set. WE4 to a non-pending register: write performed, no error. ERR cleared only by reset.
- STALL = OR over n of (RVn and BUSY[An]); forced 0 for An = NREGS-1.

## Timing
- Read latency 0 (combinational from address, stored state, R15).
- Write-to-read latency 1 cycle: data written at edge k is visible on RDn after edge k.
- Pending bit set at edge k is visible on BUSY/STALL after edge k; clear likewise.
- Reset deassertion: first write or issue takes effect at the first rising edge with RST_N high.
- Reset asserted mid-load: pending bits and ERR clear immediately; a later WE4 behaves as a write to a non-pending register.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write-to-read forwarding. If An matches an active write address (not NREGS-1), RDn returns that write data in the current cycle (WE3 priority over WE4). STALL for a register is suppressed in the cycle its WE4 is active, unless LD_ISSUE targets it in the same cycle.
- Not defined: no forwarding; RDn shows pre-edge contents; STALL holds until the cycle after WE4.

## Test plan
- Reset, then read all 16 addresses with R15 = 0x0000_1000 -> RD = 0 for 0..14, 0x0000_1000 for 15 on all three ports.
- WE3 A3=2 WD3=0xDEAD_BEEF and WE4 A4=2 WD4=0x1234_5678 same edge -> register 2 = 0xDEAD_BEEF; write to A3=15 -> no change, RD1 still R15.
- LD_ISSUE LD_ADDR=5, next cycle A1=5 RV1=1 -> STALL=1, BUSY[5]=1; WE4 A4=5 WD4=0x55 -> next cycle STALL=0, RD1=0x55 (with bypass: STALL=0 and RD1=0x55 in the WE4 cycle).
- LD_ISSUE to 7 twice without WE4 -> ERR=1, held until RST_N pulse; simultaneous LD_ISSUE and WE4 on 7 -> BUSY[7] stays 1.
- Pending on 3, RV1=0 with A1=3 -> STALL=0; RST_N low mid-load -> BUSY=0, ERR=0, STALL=0 immediately.
- DATA_W=16, ADDR_W=3 instance: PC index 7; writes/reads on 0..6 correct, 16-bit wrap of data 0xFFFF preserved.
